// File: rtl/frame_rd_ctrl.sv
// frame_rd_ctrl: scans one frame out of a synchronous frame memory
// into a valid/ready pixel stream through a 2-entry output buffer.
//
// Ports:
//   clk, reset       clock, asynchronous active-low reset
//   start            request to scan out one frame (sampled in IDLE)
//   rd_en, rd_addr   active-low memory read enable and address
//   rd_data          memory data, valid one cycle after a read edge
//   pix_data/valid   downstream word and its valid
//   pix_ready        downstream accept
//   pix_last         final word of the frame
//   busy             frame in progress (RUN or DRAIN)
//   frame_done       one-cycle pulse after the last word is accepted
module frame_rd_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 3,
    parameter int FRAME_LEN  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic [DATA_WIDTH-1:0] pix_data,
    output logic                  pix_valid,
    input  logic                  pix_ready,
    output logic                  pix_last,
    output logic                  busy,
    output logic                  frame_done
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR =
        ADDR_WIDTH'(FRAME_LEN - 1);

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic                    pend;
    logic                    pend_last;
    logic [1:0]              count;
    logic [DATA_WIDTH-1:0]   b0_data;
    logic [DATA_WIDTH-1:0]   b1_data;
    logic                    b0_last;
    logic                    b1_last;

    logic                    pop;
    logic                    push;
    logic                    room;
    logic                    issue;

    assign pop  = (count != 2'd0) && pix_ready;
    assign push = pend;

    // A word leaving the buffer on this edge frees its slot, which is
    // what lets the stream run at one word per cycle. A full buffer
    // never issues, even while draining.
    always_comb begin
        room = 1'b0;
        case (count)
            2'd0:    room = 1'b1;
            2'd1:    room = !pend || pop;
            default: room = 1'b0;
        endcase
    end

    assign issue     = (state == RUN) && room;
    assign rd_en     = !issue;
    assign rd_addr   = addr_q;
    assign pix_valid = (count != 2'd0);
    assign pix_data  = b0_data;
    assign pix_last  = pix_valid && b0_last;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            addr_q     <= '0;
            pend       <= 1'b0;
            pend_last  <= 1'b0;
            count      <= 2'd0;
            b0_data    <= '0;
            b1_data    <= '0;
            b0_last    <= 1'b0;
            b1_last    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            pend       <= issue;
            pend_last  <= issue && (addr_q == LAST_ADDR);

            case (state)
                IDLE: begin
                    if (start) begin
                        state  <= RUN;
                        addr_q <= '0;
                    end
                end
                RUN: begin
                    if (issue) begin
                        // Counter is cleared rather than wrapped so a
                        // full-address-space frame leaves no residue.
                        if (addr_q == LAST_ADDR) begin
                            state  <= DRAIN;
                            addr_q <= '0;
                        end else begin
                            addr_q <= addr_q + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (pop && b0_last) begin
                        state      <= IDLE;
                        frame_done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            case (count)
                2'd0: begin
                    if (push) begin
                        b0_data <= rd_data;
                        b0_last <= pend_last;
                        count   <= 2'd1;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        b0_data <= rd_data;
                        b0_last <= pend_last;
                    end else if (push) begin
                        b1_data <= rd_data;
                        b1_last <= pend_last;
                        count   <= 2'd2;
                    end else if (pop) begin
                        count   <= 2'd0;
                    end
                end
                default: begin
                    if (pop) begin
                        b0_data <= b1_data;
                        b0_last <= b1_last;
                        if (push) begin
                            b1_data <= rd_data;
                            b1_last <= pend_last;
                        end else begin
                            count   <= 2'd1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frame_rd_ctrl.sv
// tb_frame_rd_ctrl: randomized self-checking bench for frame_rd_ctrl
// against a frame-level model of the expected pixel stream.
module tb_frame_rd_ctrl;

    localparam int DW = 16;
    localparam int AW = 3;
    localparam int FL = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          pix_ready;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic [DW-1:0] pix_data;
    logic          pix_valid;
    logic          pix_last;
    logic          busy;
    logic          frame_done;

    logic          start1;
    logic          pix_ready1;
    logic          rd_en1;
    logic [AW-1:0] rd_addr1;
    logic [DW-1:0] rd_data1;
    logic [DW-1:0] pix_data1;
    logic          pix_valid1;
    logic          pix_last1;
    logic          busy1;
    logic          frame_done1;

    always #5 clk = ~clk;

    frame_rd_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FRAME_LEN(FL)) u_dut (
        .clk(clk), .reset(reset), .start(start),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .pix_data(pix_data), .pix_valid(pix_valid),
        .pix_ready(pix_ready), .pix_last(pix_last),
        .busy(busy), .frame_done(frame_done)
    );

    frame_rd_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FRAME_LEN(1)) u_dut1 (
        .clk(clk), .reset(reset), .start(start1),
        .rd_en(rd_en1), .rd_addr(rd_addr1), .rd_data(rd_data1),
        .pix_data(pix_data1), .pix_valid(pix_valid1),
        .pix_ready(pix_ready1), .pix_last(pix_last1),
        .busy(busy1), .frame_done(frame_done1)
    );

    // Synchronous frame memory: data one cycle after the read edge,
    // junk otherwise so a stray capture shows up.
    logic [DW-1:0] mem [FL];
    always @(posedge clk) begin
        rd_data  <= !rd_en  ? mem[rd_addr]  : DW'($urandom);
        rd_data1 <= !rd_en1 ? mem[rd_addr1] : DW'($urandom);
    end

    int n_pass = 0;
    int n_tot  = 0;

    // Monitor: records accepts, reads and frame_done; checks stall
    // stability and buffer occupancy from issued/accepted counts.
    int            cyc = 0;
    int            iss_done, acc_done, mon_buf, mon_err = 0;
    bit            prev_rd_low, prev_stall;
    logic [DW-1:0] prev_data;
    logic          prev_last;
    logic [DW:0]   acc_q [$];
    int            acc_c [$];
    logic [AW-1:0] iss_q [$];
    int            iss_c [$];
    int            fd_c  [$];
    logic [DW:0]   exp_q [$];

    always @(negedge clk) begin
        cyc++;
        if (!reset) begin
            iss_done    = 0;
            acc_done    = 0;
            prev_rd_low = 1'b0;
            prev_stall  = 1'b0;
        end else begin
            mon_buf = iss_done - (prev_rd_low ? 1 : 0) - acc_done;
            if (pix_valid !== (mon_buf > 0)) begin
                mon_err++;
                $display("monitor: pix_valid=%b buffered=%0d cyc=%0d",
                         pix_valid, mon_buf, cyc);
            end
            if (!rd_en && mon_buf >= 2) begin
                mon_err++;
                $display("monitor: read with 2 buffered cyc=%0d", cyc);
            end
            if (prev_stall && (pix_valid !== 1'b1 ||
                pix_data !== prev_data || pix_last !== prev_last)) begin
                mon_err++;
                $display("monitor: stall not stable cyc=%0d", cyc);
            end
            if (pix_valid && pix_ready) begin
                acc_q.push_back({pix_last, pix_data});
                acc_c.push_back(cyc);
                acc_done++;
            end
            if (!rd_en) begin
                iss_q.push_back(rd_addr);
                iss_c.push_back(cyc);
                iss_done++;
            end
            if (frame_done) fd_c.push_back(cyc);
            prev_rd_low = !rd_en;
            prev_stall  = pix_valid && !pix_ready;
            prev_data   = pix_data;
            prev_last   = pix_last;
        end
    end

    int rdy_mode = 0;
    int rdy_pct  = 50;

    task automatic step();
        @(posedge clk);
        #1;
        if (rdy_mode == 1) pix_ready = ~pix_ready;
        else if (rdy_mode == 2)
            pix_ready = ($urandom_range(99) < rdy_pct);
    endtask

    task automatic clr();
        acc_q.delete(); acc_c.delete();
        iss_q.delete(); iss_c.delete();
        fd_c.delete();
        mon_err = 0;
    endtask

    task automatic wait_done(input int n_fd, input int budget,
                             output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (fd_c.size() >= n_fd) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    // Reference model: a frame is mem[0..FL-1], last flag on the final.
    function automatic void model_frames(input int nf);
        exp_q.delete();
        for (int f = 0; f < nf; f++)
            for (int k = 0; k < FL; k++)
                exp_q.push_back({(k == FL - 1), mem[k]});
    endfunction

    function automatic void mem_ramp();
        for (int k = 0; k < FL; k++) mem[k] = DW'(k + 1);
    endfunction

    task automatic test_reset();
        logic [DW+AW+4:0] got;
        reset = 1'b0; start = 1'b0; start1 = 1'b0;
        pix_ready = 1'b0; pix_ready1 = 1'b0;
        mem_ramp();
        repeat (3) step();
        got = {rd_en, rd_addr, pix_valid, pix_data, pix_last,
               busy, frame_done};
        n_tot++;
        if (got !== {1'b1, {AW{1'b0}}, 1'b0, {DW{1'b0}}, 3'b000})
            $display("FAIL reset_outs got=%h req=%h", got,
                     {1'b1, {AW{1'b0}}, 1'b0, {DW{1'b0}}, 3'b000});
        else n_pass++;
        n_tot++;
        if ({rd_en1, pix_valid1, busy1, frame_done1} !== 4'b1000)
            $display("FAIL reset_outs1 got=%b req=1000",
                     {rd_en1, pix_valid1, busy1, frame_done1});
        else n_pass++;
        reset = 1'b1;
        repeat (2) step();
    endtask

    task automatic test_basic();
        int s;
        bit ok, bad;
        clr();
        mem_ramp();
        rdy_mode = 0; pix_ready = 1'b1;
        start = 1'b1; s = cyc + 1;
        step();
        start = 1'b0;
        wait_done(1, 60, ok);
        repeat (3) step();
        n_tot++;
        if (!ok) $display("FAIL basic_timeout got=0 req=1");
        else n_pass++;
        model_frames(1);
        bad = (acc_q.size() != exp_q.size());
        for (int i = 0; i < acc_q.size() && !bad; i++)
            if (acc_q[i] !== exp_q[i]) bad = 1'b1;
        n_tot++;
        if (bad) $display("FAIL basic_seq got_n=%0d req_n=%0d",
                          acc_q.size(), exp_q.size());
        else n_pass++;
        if (acc_c.size() == FL && fd_c.size() >= 1) begin
            n_tot++;
            if (acc_c[0] != s + 3)
                $display("FAIL basic_first got=%0d req=%0d",
                         acc_c[0] - s, 3);
            else n_pass++;
            n_tot++;
            if (acc_c[FL-1] != acc_c[0] + FL - 1)
                $display("FAIL basic_rate got=%0d req=%0d",
                         acc_c[FL-1] - acc_c[0], FL - 1);
            else n_pass++;
            n_tot++;
            if (fd_c.size() != 1 || fd_c[0] != acc_c[FL-1] + 1)
                $display("FAIL basic_done got=%0d req=%0d",
                         fd_c[0], acc_c[FL-1] + 1);
            else n_pass++;
        end
        bad = (iss_q.size() != FL);
        for (int i = 0; i < iss_q.size() && !bad; i++)
            if (iss_q[i] != AW'(i)) bad = 1'b1;
        n_tot++;
        if (bad) $display("FAIL basic_addrs got_n=%0d req_n=%0d",
                          iss_q.size(), FL);
        else n_pass++;
        n_tot++;
        if (mon_err != 0 || busy !== 1'b0)
            $display("FAIL basic_proto got=%0d/%b req=0/0",
                     mon_err, busy);
        else n_pass++;
    endtask

    task automatic test_toggle();
        bit ok, bad;
        clr();
        rdy_mode = 1; pix_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done(1, 80, ok);
        repeat (3) step();
        rdy_mode = 0; pix_ready = 1'b1;
        model_frames(1);
        bad = !ok || (acc_q.size() != exp_q.size());
        for (int i = 0; i < acc_q.size() && !bad; i++)
            if (acc_q[i] !== exp_q[i]) bad = 1'b1;
        n_tot++;
        if (bad) $display("FAIL toggle_seq got_n=%0d req_n=%0d",
                          acc_q.size(), exp_q.size());
        else n_pass++;
        n_tot++;
        if (mon_err != 0)
            $display("FAIL toggle_proto got=%0d req=0", mon_err);
        else n_pass++;
    endtask

    task automatic test_hold_off();
        bit ok, bad;
        clr();
        rdy_mode = 0; pix_ready = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (10) step();
        n_tot++;
        if (iss_q.size() != 2 || iss_q[0] != 0 || iss_q[1] != 1)
            $display("FAIL hold_reads got=%0d req=2", iss_q.size());
        else n_pass++;
        n_tot++;
        if (pix_valid !== 1'b1 || pix_data !== 16'd1)
            $display("FAIL hold_head got=%b/%0d req=1/1",
                     pix_valid, pix_data);
        else n_pass++;
        pix_ready = 1'b1;
        wait_done(1, 60, ok);
        repeat (3) step();
        model_frames(1);
        bad = !ok || (acc_q.size() != exp_q.size());
        for (int i = 0; i < acc_q.size() && !bad; i++)
            if (acc_q[i] !== exp_q[i]) bad = 1'b1;
        n_tot++;
        if (bad || mon_err != 0)
            $display("FAIL hold_seq got_n=%0d req_n=%0d err=%0d",
                     acc_q.size(), exp_q.size(), mon_err);
        else n_pass++;
    endtask

    task automatic test_random();
        bit ok, bad;
        for (int f = 0; f < 6; f++) begin
            clr();
            for (int k = 0; k < FL; k++) mem[k] = DW'($urandom);
            rdy_pct  = $urandom_range(90, 15);
            rdy_mode = 2;
            start = 1'b1;
            step();
            start = 1'b0;
            wait_done(1, 200, ok);
            repeat (3) step();
            rdy_mode = 0; pix_ready = 1'b1;
            model_frames(1);
            bad = !ok || (acc_q.size() != exp_q.size());
            for (int i = 0; i < acc_q.size() && !bad; i++)
                if (acc_q[i] !== exp_q[i]) bad = 1'b1;
            n_tot++;
            if (bad || mon_err != 0)
                $display("FAIL random_%0d got_n=%0d req_n=%0d err=%0d",
                         f, acc_q.size(), exp_q.size(), mon_err);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        bit ok1, ok2, bad;
        clr();
        mem_ramp();
        rdy_mode = 0; pix_ready = 1'b1;
        start = 1'b1;
        wait_done(1, 60, ok1);
        repeat (3) step();
        start = 1'b0;
        wait_done(2, 60, ok2);
        repeat (3) step();
        model_frames(2);
        bad = !ok1 || !ok2 || (acc_q.size() != exp_q.size());
        for (int i = 0; i < acc_q.size() && !bad; i++)
            if (acc_q[i] !== exp_q[i]) bad = 1'b1;
        n_tot++;
        if (bad) $display("FAIL b2b_seq got_n=%0d req_n=%0d",
                          acc_q.size(), exp_q.size());
        else n_pass++;
        n_tot++;
        if (iss_q.size() != 2 * FL || fd_c.size() != 2)
            $display("FAIL b2b_reads got=%0d/%0d req=%0d/2",
                     iss_q.size(), fd_c.size(), 2 * FL);
        else n_pass++;
        if (iss_q.size() == 2 * FL && fd_c.size() == 2) begin
            n_tot++;
            if (iss_q[FL] != 0 || iss_c[FL] != fd_c[0] + 1)
                $display("FAIL b2b_restart got=%0d req=%0d",
                         iss_c[FL], fd_c[0] + 1);
            else n_pass++;
        end
        n_tot++;
        if (mon_err != 0 || busy !== 1'b0)
            $display("FAIL b2b_proto got=%0d/%b req=0/0",
                     mon_err, busy);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [DW+AW+4:0] got;
        bit ok, bad;
        clr();
        mem_ramp();
        rdy_mode = 0; pix_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 40 && acc_q.size() < 3; i++) step();
        #2 reset = 1'b0;
        #1;
        got = {rd_en, rd_addr, pix_valid, pix_data, pix_last,
               busy, frame_done};
        n_tot++;
        if (got !== {1'b1, {AW{1'b0}}, 1'b0, {DW{1'b0}}, 3'b000})
            $display("FAIL midrst_outs got=%h req=%h", got,
                     {1'b1, {AW{1'b0}}, 1'b0, {DW{1'b0}}, 3'b000});
        else n_pass++;
        repeat (2) step();
        reset = 1'b1;
        step();
        clr();
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done(1, 60, ok);
        repeat (3) step();
        model_frames(1);
        bad = !ok || (acc_q.size() != exp_q.size());
        for (int i = 0; i < acc_q.size() && !bad; i++)
            if (acc_q[i] !== exp_q[i]) bad = 1'b1;
        n_tot++;
        if (bad || iss_q.size() == 0 || iss_q[0] != 0)
            $display("FAIL midrst_seq got_n=%0d req_n=%0d",
                     acc_q.size(), exp_q.size());
        else n_pass++;
    endtask

    task automatic test_len1();
        mem_ramp();
        pix_ready1 = 1'b0;
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        step();
        n_tot++;
        if (pix_valid1 !== 1'b0)
            $display("FAIL len1_early got=%b req=0", pix_valid1);
        else n_pass++;
        step();
        n_tot++;
        if ({pix_valid1, pix_last1, busy1, pix_data1} !==
            {3'b111, 16'd1})
            $display("FAIL len1_word got=%b%b%b/%0d req=111/1",
                     pix_valid1, pix_last1, busy1, pix_data1);
        else n_pass++;
        pix_ready1 = 1'b1;
        step();
        n_tot++;
        if ({frame_done1, pix_valid1, busy1} !== 3'b100)
            $display("FAIL len1_done got=%b req=100",
                     {frame_done1, pix_valid1, busy1});
        else n_pass++;
        step();
        n_tot++;
        if (frame_done1 !== 1'b0)
            $display("FAIL len1_pulse got=%b req=0", frame_done1);
        else n_pass++;
        pix_ready1 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_toggle();
        test_hold_off();
        test_random();
        test_back_to_back();
        test_reset_mid();
        test_len1();
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/frame_rd_ctrl.md
FRAME_RD_CTRL -- requirements
Module: frame_rd_ctrl

Interface
REQ-001 The block SHALL provide parameter DATA_WIDTH, default 16, pixel/memory word width.
REQ-002 The block SHALL provide parameter ADDR_WIDTH, default 3, memory address width.
REQ-003 The block SHALL provide parameter FRAME_LEN, default 8, words per frame; legal range 1..2^ADDR_WIDTH.
REQ-004 The block SHALL provide port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 The block SHALL provide port reset, input, 1, asynchronous, active-low reset.
REQ-006 The block SHALL provide port start, input, 1, active-high request to scan out one frame.
REQ-007 The block SHALL provide port rd_en, output, 1, active-low frame-memory read enable.
REQ-008 The block SHALL provide port rd_addr, output, ADDR_WIDTH, frame-memory read address.
REQ-009 The block SHALL provide port rd_data, input, DATA_WIDTH, frame-memory read data, valid exactly one cycle after the edge sampling rd_en low.
REQ-010 The block SHALL provide port pix_data, output, DATA_WIDTH, downstream pixel word.
REQ-011 The block SHALL provide port pix_valid, output, 1, pix_data valid.
REQ-012 The block SHALL provide port pix_ready, input, 1, downstream accepts the word when pix_valid and pix_ready are both high at an edge.
REQ-013 The block SHALL provide port pix_last, output, 1, high with the final word of a frame.
REQ-014 The block SHALL provide port busy, output, 1, high in RUN or DRAIN.
REQ-015 The block SHALL provide port frame_done, output, 1, one-cycle pulse after the last word is accepted.

Function
REQ-016 The block SHALL implement states IDLE, RUN, DRAIN.
REQ-017 IDLE: start high at an edge -> RUN, read address counter = 0; otherwise stay.
REQ-018 RUN: rd_en SHALL be driven low combinationally when outstanding + buffered words < 2, with rd_addr = counter. Counter SHALL increment on each edge where rd_en is low.
REQ-019 RUN -> DRAIN on the edge issuing address FRAME_LEN-1; rd_en SHALL stay high in DRAIN and IDLE.
REQ-020 Returned rd_data SHALL be captured into a 2-entry output buffer, entry from address k in a FIFO order; no word SHALL be dropped or duplicated under any pix_ready pattern.
REQ-021 pix_valid/pix_data SHALL reflect buffer head; while pix_valid high and pix_ready low, pix_data and pix_last SHALL stay stable.
REQ-022 With pix_ready held high, the block SHALL sustain one word per cycle; first pix_valid SHALL rise after the second edge following the start edge (start edge N, read issued cycle N..N+1, data captured edge N+2).
REQ-023 pix_last SHALL be high only with the word read from address FRAME_LEN-1.
REQ-024 DRAIN -> IDLE on the edge accepting the pix_last word; frame_done SHALL be high for exactly the following cycle.
REQ-025 start SHALL be ignored in RUN and DRAIN; start in the frame_done cycle (state IDLE) SHALL begin a new frame.
REQ-026 Simultaneous capture and acceptance in one edge SHALL keep buffer occupancy unchanged.
REQ-027 FRAME_LEN = 2^ADDR_WIDTH SHALL read the full address space with no counter overflow side effect.

Reset
REQ-028 reset low SHALL asynchronously force: state IDLE, rd_en = 1, rd_addr = 0, pix_valid = 0, pix_data = 0, pix_last = 0, busy = 0, frame_done = 0, buffer empty, outstanding count 0.
REQ-029 reset mid-frame SHALL abort the frame; rd_data returning after reset release SHALL be discarded.

Verification
REQ-030 Memory preloaded addr k = k+1, FRAME_LEN 8, pix_ready high, start pulse -> pix_data 1..8 on 8 consecutive cycles, pix_last with 8, frame_done one cycle later.
REQ-031 Same preload, pix_ready toggling 1/0 each cycle -> sequence 1..8 unchanged, pix_data stable during stalls, rd_en never low with 2 words buffered.
REQ-032 pix_ready low for 10 cycles after start -> exactly 2 reads issued (addr 0,1), pix_data = 1 held; on release, remaining 3..8 follow.
REQ-033 start held high continuously -> back-to-back frames, second frame's addr 0 read issued after frame_done, no start accepted while busy.
REQ-034 reset asserted low after 3 words accepted -> all outputs at reset values immediately; new start after release yields 1..8 from addr 0.
REQ-035 FRAME_LEN 1 -> single word 1 with pix_last high, frame_done one cycle after acceptance.
